imem_fetch_queue: RTL and testbench
===================================

// Module: imem_fetch_queue
// PURPOSE
// - Downstream neighbour of the PC/fetch stage: takes the current PC, issues in-order reads to instruction memory,
//   buffers returned words with their PC, presents {pc, inst} to decode over a valid/ready handshake.
// - Generates pc_advance (drives the PC stage's valid) only when a request is accepted.
// - Absorbs variable imem latency; discards in-flight responses on a redirect (branch/jal/jalr).
// PARAMETERS
// - DEPTH     2   queue entries = max outstanding + buffered instructions; power of two, >= 2
// - XLEN      32  address/data width (from package)
// PORTS
// - clk             in   1      clock; all logic on rising edge
// - rst             in   1      synchronous, active-high reset
// - pc_address_in   in   32     current PC from the fetch/PC stage
// - redirect        in   1      branch taken | jal | jalr this cycle; flush queue
// - pc_advance      out  1      request accepted this cycle; PC stage steps to pc+4 or redirect target
// - imem_req_valid  out  1      read request valid
// - imem_req_ready  in   1      imem accepts request
// - imem_req_addr   out  32     = pc_address_in
// - imem_rsp_valid  in   1      read data valid; responses in request order, >= 1 cycle after accept
// - imem_rsp_data   in   32     instruction word
// - inst_valid      out  1      head entry holds a returned instruction
// - inst_ready      in   1      decode consumes head
// - inst_out        out  32     head instruction
// - inst_pc_out     out  32     PC of head instruction
// BEHAVIOUR
// - Reset: pointers, count, drop_cnt = 0; inst_valid, imem_req_valid, pc_advance = 0; inst_out = 32'h00000013 (NOP), inst_pc_out = 0.
// - Entry = {pc, inst, filled}. Slot allocated at request accept (pc written, filled=0); filled on response.
// - imem_req_valid = !rst && !redirect && (alloc_cnt < DEPTH). Accept = req_valid && req_ready -> pc_advance=1, alloc.
// - Response with drop_cnt==0: writes inst into oldest unfilled slot, sets filled. With drop_cnt>0: discarded, drop_cnt--.
// - inst_valid = head.filled (registered state, no combinational path from imem_rsp_valid). Pop on inst_valid && inst_ready.
// - Alloc and pop in same cycle: count unchanged. Full (alloc_cnt==DEPTH): no request, pc_advance=0.
// - Empty: inst_valid=0, inst_out holds last value. Pointers wrap modulo DEPTH.
// - redirect: next cycle all entries invalid, pointers/count=0; drop_cnt <= number of allocated-but-unfilled slots
//   (including any response arriving in the redirect cycle being counted as dropped: drop_cnt = unfilled - rsp_valid).
//   No request issued and no pop in the redirect cycle; inst_valid forced 0 that cycle.
// - New requests after redirect may overlap draining drop_cnt; ordering guarantees drops are oldest-first.
// - Reset mid-operation: immediate return to reset state; imem must also be reset (no drop tracking across reset).
// - Latency: request accept at cycle N, response at N+k -> inst_valid at N+k+1.
// CONFIGURATION
// - IFQ_MISALIGN_CHECK_EN defined: if pc_address_in[1:0]!=0, no imem request; slot allocated pre-filled with
//   inst=NOP and extra output inst_misaligned=1 for that entry (pc_advance=1). Decode raises the exception.
// - Undefined: inst_misaligned port absent; address sent to imem unchanged.
// STRUCTURE
// - rv32i_pkg: XLEN, NOP_INST = 32'h00000013, ifq entry struct/typedef.
// - Sub-module ifq_slot_ram: DEPTH x {pc, inst, filled} storage with alloc/fill/pop pointers; top holds control + drop_cnt.
// TESTING
// - Reset: rst=1 two cycles -> inst_valid=0, imem_req_valid=0, inst_out=32'h00000013, inst_pc_out=0.
// - Streaming, req_ready=1, 1-cycle rsp, inst_ready=1: PCs 0,4,8 -> inst out in order with matching inst_pc_out, one per cycle.
// - Backpressure: inst_ready=0, DEPTH=2 -> after 2 accepts imem_req_valid=0, pc_advance=0; release -> resumes, no loss.
// - Redirect with 2 outstanding: redirect at PC 8 -> both late responses dropped; next inst_pc_out = new target 0x100.
// - Redirect coincident with response: that response dropped, drop_cnt decrements correctly, no stale inst_valid.
// - IFQ_MISALIGN_CHECK_EN: pc=0x102 -> no imem request, inst_misaligned=1, inst_out=NOP, inst_pc_out=0x102.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the fetch-queue entry layout used by the imem fetch queue.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  // Sized for several back-to-back redirects while the memory is still returning old reads.
  localparam int unsigned DROP_W = 8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            filled;
    logic            misaligned;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_slot_ram.sv
// Circular slot storage for the fetch queue: allocate at tail, fill oldest unfilled slot,
// pop at head. Free slots always read back with filled=0.
module ifq_slot_ram
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned IdxW = $clog2(DEPTH),
  localparam int unsigned CntW = IdxW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            alloc_i,
  input  logic [XLEN-1:0] alloc_pc_i,
  input  logic            alloc_misaligned_i,
  input  logic            fill_i,
  input  logic [XLEN-1:0] fill_inst_i,
  input  logic            pop_i,
  output ifq_entry_t      head_o,
  output logic [CntW-1:0] unfilled_o,
  output logic            full_o,
  output logic            fill_avail_o
);

  ifq_entry_t      slot_q [DEPTH];
  logic [IdxW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q, count_d;
  logic [IdxW-1:0] fill_idx;
  logic [CntW-1:0] filled_cnt;
  logic            found;

  // Oldest unfilled slot, searched from the head across allocated entries only.
  always_comb begin
    fill_idx   = head_q;
    found      = 1'b0;
    filled_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      filled_cnt = filled_cnt + CntW'(slot_q[i].filled);
      if (!found && (CntW'(i) < count_q) && !slot_q[head_q + IdxW'(i)].filled) begin
        fill_idx = head_q + IdxW'(i);
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (alloc_i && !pop_i) begin
      count_d = count_q + CntW'(1);
    end else if (!alloc_i && pop_i) begin
      count_d = count_q - CntW'(1);
    end
  end

  assign head_o       = slot_q[head_q];
  assign full_o       = (count_q == CntW'(DEPTH));
  assign unfilled_o   = count_q - filled_cnt;
  assign fill_avail_o = found;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i].filled     <= 1'b0;
        slot_q[i].misaligned <= 1'b0;
      end
    end else begin
      count_q <= count_d;
      if (pop_i) begin
        slot_q[head_q].filled     <= 1'b0;
        slot_q[head_q].misaligned <= 1'b0;
        head_q                    <= head_q + IdxW'(1);
      end
      if (fill_i) begin
        slot_q[fill_idx].inst   <= fill_inst_i;
        slot_q[fill_idx].filled <= 1'b1;
      end
      // A misaligned fetch never reaches memory, so its slot is born complete.
      if (alloc_i) begin
        slot_q[tail_q].pc         <= alloc_pc_i;
        slot_q[tail_q].inst       <= NOP_INST;
        slot_q[tail_q].filled     <= alloc_misaligned_i;
        slot_q[tail_q].misaligned <= alloc_misaligned_i;
        tail_q                    <= tail_q + IdxW'(1);
      end
    end
  end

endmodule

// File: rtl/imem_fetch_queue.sv
// Instruction fetch queue between the PC stage and decode; tracks in-flight imem reads and
// drops stale responses after a redirect. IFQ_MISALIGN_CHECK_EN enables misaligned-PC trapping.
module imem_fetch_queue
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_address_in,
  input  logic            redirect,
  output logic            pc_advance,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc_out
`ifdef IFQ_MISALIGN_CHECK_EN
  ,
  output logic            inst_misaligned
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  ifq_entry_t        head;
  logic [CntW-1:0]   unfilled;
  logic              full;
  logic              fill_avail;
  logic              pc_misaligned;
  logic              can_alloc;
  logic              alloc;
  logic              fill;
  logic              pop;
  logic              rsp_drop;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [XLEN-1:0]   last_inst_q, last_pc_q;

`ifdef IFQ_MISALIGN_CHECK_EN
  assign pc_misaligned   = (pc_address_in[1:0] != 2'b00);
  assign inst_misaligned = inst_valid && head.misaligned;
`else
  logic unused_misaligned;
  assign pc_misaligned     = 1'b0;
  assign unused_misaligned = head.misaligned;
`endif

  always_comb begin
    can_alloc      = !rst && !redirect && !full;
    imem_req_valid = can_alloc && !pc_misaligned;
    alloc          = (imem_req_valid && imem_req_ready) || (can_alloc && pc_misaligned);
    pc_advance     = alloc;
    imem_req_addr  = pc_address_in;
    inst_valid     = !rst && !redirect && head.filled;
    pop            = inst_valid && inst_ready;
    rsp_drop       = imem_rsp_valid && (drop_cnt_q != '0);
    fill           = imem_rsp_valid && !rsp_drop && !redirect && fill_avail;
    inst_out       = inst_valid ? head.inst : last_inst_q;
    inst_pc_out    = inst_valid ? head.pc : last_pc_q;
  end

  // Responses are in order, so pending drops always belong to the oldest outstanding reads.
  // A response landing in the redirect cycle itself is one of those being discarded.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (redirect) begin
      drop_cnt_d = drop_cnt_q + DROP_W'(unfilled);
      if (imem_rsp_valid && (drop_cnt_d != '0)) begin
        drop_cnt_d = drop_cnt_d - DROP_W'(1);
      end
    end else if (rsp_drop) begin
      drop_cnt_d = drop_cnt_q - DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q  <= '0;
      last_inst_q <= NOP_INST;
      last_pc_q   <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      if (inst_valid) begin
        last_inst_q <= head.inst;
        last_pc_q   <= head.pc;
      end
    end
  end

  ifq_slot_ram #(
    .DEPTH(DEPTH)
  ) u_slots (
    .clk_i              (clk),
    .rst_i              (rst),
    .flush_i            (redirect),
    .alloc_i            (alloc),
    .alloc_pc_i         (pc_address_in),
    .alloc_misaligned_i (pc_misaligned),
    .fill_i             (fill),
    .fill_inst_i        (imem_rsp_data),
    .pop_i              (pop),
    .head_o             (head),
    .unfilled_o         (unfilled),
    .full_o             (full),
    .fill_avail_o       (fill_avail)
  );

endmodule

// File: tb/tb_imem_fetch_queue.sv
// Randomized scoreboard bench for imem_fetch_queue: the bench plays PC stage, imem and decode.
module tb_imem_fetch_queue;
  import rv32i_pkg::*;

  localparam int unsigned Depth = 2;
`ifdef IFQ_MISALIGN_CHECK_EN
  localparam bit MisEn = 1'b1;
`else
  localparam bit MisEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_address_in;
  logic        redirect;
  logic        pc_advance;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc_out;
`ifdef IFQ_MISALIGN_CHECK_EN
  logic        inst_misaligned;
`endif

  always #5 clk = ~clk;

  imem_fetch_queue #(
    .DEPTH(Depth)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_address_in  (pc_address_in),
    .redirect       (redirect),
    .pc_advance     (pc_advance),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc_out    (inst_pc_out)
`ifdef IFQ_MISALIGN_CHECK_EN
    ,
    .inst_misaligned(inst_misaligned)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  typedef struct packed {
    logic [31:0] addr;
    int unsigned due;
  } req_t;

  exp_t        exp_q[$];   // accepted fetches not yet consumed by decode
  req_t        imem_q[$];  // reads the memory still owes, in order
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned last_due = 0;
  logic [31:0] pc = 32'h0;
  bit          done = 1'b0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  function automatic logic is_mis(logic [31:0] a);
    return MisEn && (a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = 32'($urandom_range(0, 4095)) << 2;
    if (MisEn && ($urandom_range(0, 3) == 0)) t = t | 32'd2;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One bus cycle: drive at posedge+1, evaluate what the coming edge commits at negedge.
  task automatic run_cycle(input int pr, input int pi, input int pd, input int lmin,
                           input int lmax, input bit frc, input logic [31:0] tgt);
    logic        mis, can, acc;
    logic [31:0] new_tgt;
    int unsigned due;
    @(posedge clk);
    #1;
    cyc++;
    imem_req_ready = ($urandom_range(0, 99) < pr);
    inst_ready     = ($urandom_range(0, 99) < pi);
    redirect       = frc || ($urandom_range(0, 99) < pd);
    new_tgt        = frc ? tgt : rand_target();
    pc_address_in  = pc;
    if (imem_q.size() > 0 && imem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(imem_q[0].addr);
      void'(imem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    mis = is_mis(pc);
    can = !redirect && (exp_q.size() < Depth);
    acc = can && (mis || imem_req_ready);
    check("req_valid", 32'(imem_req_valid), 32'(can && !mis));
    check("pc_advance", 32'(pc_advance), 32'(acc));
    if (can && !mis) check("req_addr", imem_req_addr, pc);
    if (redirect) begin
      check("inst_valid_in_redirect", 32'(inst_valid), 32'd0);
      exp_q.delete();
      pc = new_tgt;
    end else if (acc) begin
      if (mis) begin
        exp_q.push_back('{pc: pc, inst: NOP_INST, mis: 1'b1});
      end else begin
        exp_q.push_back('{pc: pc, inst: mem_word(pc), mis: 1'b0});
        due = cyc + 32'($urandom_range(lmin, lmax));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        imem_q.push_back('{addr: pc, due: due});
      end
      pc = pc + 32'd4;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst            = 1'b1;
    redirect       = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_inst_valid", 32'(inst_valid), 32'd0);
    check("reset_req_valid", 32'(imem_req_valid), 32'd0);
    check("reset_pc_advance", 32'(pc_advance), 32'd0);
    check("reset_inst_out", inst_out, 32'h0000_0013);
    check("reset_inst_pc_out", inst_pc_out, 32'h0);
    exp_q.delete();
    imem_q.delete();
    pc       = 32'h0;
    last_due = cyc;
    rst      = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && imem_q.size() == 0) break;
      run_cycle(0, 100, 0, 1, 1, 1'b0, 32'h0);
    end
    run_cycle(0, 100, 0, 1, 1, 1'b0, 32'h0);
    check("drain_expected_left", 32'(exp_q.size()), 32'd0);
    check("drain_imem_left", 32'(imem_q.size()), 32'd0);
  endtask

  // Decode-side monitor: every consumed instruction must be the oldest surviving fetch.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (done) break;
      if (!rst && inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_inst: got pc %h inst %h, expected nothing (cycle %0d)",
                   inst_pc_out, inst_out, cyc);
        end else begin
          e = exp_q.pop_front();
          check("inst_pc_out", inst_pc_out, e.pc);
          check("inst_out", inst_out, e.inst);
`ifdef IFQ_MISALIGN_CHECK_EN
          check("inst_misaligned", 32'(inst_misaligned), 32'(e.mis));
`endif
        end
      end
    end
  end

  initial begin : stimulus
    rst            = 1'b1;
    redirect       = 1'b0;
    pc_address_in  = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    inst_ready     = 1'b0;
    do_reset();

    // Streaming with single-cycle memory and an always-ready decode.
    repeat (20) run_cycle(100, 100, 0, 1, 1, 1'b0, 32'h0);
    // Decode stalls: queue must fill and stop requesting, then resume without loss.
    repeat (8) run_cycle(100, 0, 0, 1, 1, 1'b0, 32'h0);
    repeat (10) run_cycle(100, 100, 0, 1, 1, 1'b0, 32'h0);
    drain();

    // Two slow reads outstanding (PC 0 and 4), redirect at PC 8 to 0x100.
    pc = 32'h0;
    repeat (2) run_cycle(100, 100, 0, 4, 4, 1'b0, 32'h0);
    run_cycle(100, 100, 0, 1, 1, 1'b1, 32'h100);
    repeat (12) run_cycle(100, 100, 0, 1, 1, 1'b0, 32'h0);
    drain();

    // Redirect lands on the same cycle as the first outstanding response.
    pc = 32'h40;
    repeat (2) run_cycle(100, 100, 0, 2, 2, 1'b0, 32'h0);
    run_cycle(100, 100, 0, 1, 1, 1'b1, 32'h200);
    repeat (12) run_cycle(100, 100, 0, 1, 1, 1'b0, 32'h0);
    drain();

    // Random traffic: variable latency, backpressure on both sides, frequent redirects.
    repeat (3000) run_cycle(75, 70, 8, 1, 4, 1'b0, 32'h0);
    drain();

    // Reset in the middle of traffic, then confirm normal operation restarts.
    repeat (25) run_cycle(75, 70, 8, 1, 4, 1'b0, 32'h0);
    do_reset();
    repeat (20) run_cycle(100, 100, 0, 1, 2, 1'b0, 32'h0);
    drain();

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
